// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM search controller: FSM encoding,
// default geometry and the index-width helper.
package tcam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int calc_idxw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/feynman_xor_row.sv
// Two-input Feynman (CNOT) gate primitive and a WIDTH-wide row of them.
// P passes A through unchanged; Q carries A ^ B.
module feynman_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_p,
  output logic o_q
);

  assign o_p = i_a;
  assign o_q = i_a ^ i_b;

endmodule

module feynman_xor_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p,
  output logic [WIDTH-1:0] o_q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_gate
    feynman_gate u_gate (
      .i_a (i_a[g]),
      .i_b (i_b[g]),
      .o_p (o_p[g]),
      .o_q (o_q[g])
    );
  end

endmodule

// File: rtl/tcam_search_ctrl.sv
// Sequential ternary-CAM search controller: one entry compared per cycle
// through a shared Feynman XOR row, lowest matching index reported.
module tcam_search_ctrl
  import tcam_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDXW  = calc_idxw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  output logic             wr_ready,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_care,
  input  logic             wr_vld,
  input  logic             search_valid,
  output logic             search_ready,
  input  logic [WIDTH-1:0] search_key,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             result_hit,
  output logic [IDXW-1:0]  result_index
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [WIDTH-1:0] r_care [DEPTH];
  logic [DEPTH-1:0] r_valid;

  state_t           r_state;
  logic [WIDTH-1:0] r_key;
  logic [IDXW-1:0]  r_idx;
  logic             r_hit;
  logic [IDXW-1:0]  r_index;

  logic             w_wrAccept;
  logic [WIDTH-1:0] w_keyPass;
  logic [WIDTH-1:0] w_diff;
  logic             w_match;

  assign wr_ready     = (r_state != SCAN);
  assign search_ready = (r_state == IDLE);
  assign result_valid = (r_state == DONE);
  assign result_hit   = r_hit;
  assign result_index = r_index;
  assign w_wrAccept   = wr_en && wr_ready;

  feynman_xor_row #(.WIDTH(WIDTH)) u_row (
    .i_a (r_key),
    .i_b (r_data[r_idx]),
    .o_p (w_keyPass),
    .o_q (w_diff)
  );

  assign w_match = r_valid[r_idx] && ((w_diff & r_care[r_idx]) == '0);

  // Table storage; writes are only accepted outside SCAN so a scan sees a frozen table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_care[i] <= '0;
      end
    end else if (w_wrAccept) begin
      r_data[wr_addr]  <= wr_data;
      r_care[wr_addr]  <= wr_care;
      r_valid[wr_addr] <= wr_vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_hit   <= 1'b0;
      r_index <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (search_valid) begin
            r_key   <= search_key;
            r_idx   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          // The key recirculates through the row's pass-through output while scanning.
          r_key <= w_keyPass;
          if (w_match) begin
            r_hit   <= 1'b1;
            r_index <= r_idx;
            r_state <= DONE;
          end else if (r_idx == LAST_IDX) begin
            r_hit   <= 1'b0;
            r_index <= '0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_search_ctrl.sv
// Self-checking bench for tcam_search_ctrl: directed scenarios followed by
// randomized writes/searches compared against a table-level reference model.
module tb_tcam_search_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic             wr_ready;
  logic [IDXW-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] wr_care;
  logic             wr_vld;
  logic             search_valid;
  logic             search_ready;
  logic [WIDTH-1:0] search_key;
  logic             result_valid;
  logic             result_ready;
  logic             result_hit;
  logic [IDXW-1:0]  result_index;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mData  [DEPTH];
  logic [WIDTH-1:0] mCare  [DEPTH];
  bit               mValid [DEPTH];

  tcam_search_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_care      (wr_care),
    .wr_vld       (wr_vld),
    .search_valid (search_valid),
    .search_ready (search_ready),
    .search_key   (search_key),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_hit   (result_hit),
    .result_index (result_index)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: first valid entry whose cared-about bits equal the key's.
  function automatic void modelSearch(input logic [WIDTH-1:0] key, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && mValid[i] && (((key ^ mData[i]) & mCare[i]) == '0)) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < DEPTH; i++) begin
      mValid[i] = 1'b0;
      mData[i]  = '0;
      mCare[i]  = '0;
    end
  endfunction

  task automatic doWrite(input logic [IDXW-1:0] addr, input logic [WIDTH-1:0] data,
                         input logic [WIDTH-1:0] care, input bit vld);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_care = care; wr_vld = vld;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mData[addr] = data; mCare[addr] = care; mValid[addr] = vld;
  endtask

  // One full search transaction: accept, latency, result, optional hold in DONE, release.
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] key, input int holdCycles,
                               input bit withWrite, input logic [IDXW-1:0] wAddr,
                               input logic [WIDTH-1:0] wData, input logic [WIDTH-1:0] wCare,
                               input bit wVld, input bit doneWrite, input logic [WIDTH-1:0] doneData);
    bit expHit;
    int expIdx;
    int expLat;
    int lat;
    @(negedge clk);
    checkOutput({tag, "/search_ready_idle"}, 32'(search_ready), 32'd1);
    search_valid = 1'b1;
    search_key   = key;
    if (withWrite) begin
      wr_en = 1'b1; wr_addr = wAddr; wr_data = wData; wr_care = wCare; wr_vld = wVld;
    end
    @(posedge clk); #1;
    search_valid = 1'b0;
    wr_en        = 1'b0;
    if (withWrite) begin
      mData[wAddr] = wData; mCare[wAddr] = wCare; mValid[wAddr] = wVld;
    end
    modelSearch(key, expHit, expIdx);
    expLat = expHit ? expIdx + 1 : DEPTH;
    lat = 0;
    while (!result_valid && lat < 4 * DEPTH) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "/latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "/hit"}, 32'(result_hit), 32'(expHit));
    checkOutput({tag, "/index"}, 32'(result_index), expHit ? 32'(expIdx) : 32'd0);
    checkOutput({tag, "/wr_ready_done"}, 32'(wr_ready), 32'd1);
    checkOutput({tag, "/search_ready_done"}, 32'(search_ready), 32'd0);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      if (doneWrite && h == 0) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = doneData; wr_care = '1; wr_vld = 1'b1;
      end
      @(posedge clk); #1;
      if (wr_en) begin
        wr_en = 1'b0;
        mData[0] = doneData; mCare[0] = '1; mValid[0] = 1'b1;
      end
      checkOutput({tag, "/hold_valid"}, 32'(result_valid), 32'd1);
      checkOutput({tag, "/hold_hit"}, 32'(result_hit), 32'(expHit));
      checkOutput({tag, "/hold_index"}, 32'(result_index), expHit ? 32'(expIdx) : 32'd0);
      checkOutput({tag, "/hold_search_ready"}, 32'(search_ready), 32'd0);
      checkOutput({tag, "/hold_wr_ready"}, 32'(wr_ready), 32'd1);
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    checkOutput({tag, "/released"}, 32'(result_valid), 32'd0);
  endtask

  task automatic simpleSearch(input string tag, input logic [WIDTH-1:0] key);
    applyStimulus(tag, key, 0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_care = '0; wr_vld = 1'b0;
    search_valid = 1'b0; search_key = '0; result_ready = 1'b0;
    modelClear();
    #1;
    checkOutput("reset/result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset/search_ready", 32'(search_ready), 32'd1);
    checkOutput("reset/wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset/result_hit", 32'(result_hit), 32'd0);
    checkOutput("reset/result_index", 32'(result_index), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    simpleSearch("emptyMiss", 8'h5A);

    doWrite(3'd3, 8'hA5, 8'hFF, 1'b1);
    simpleSearch("exactHit3", 8'hA5);

    doWrite(3'd1, 8'h30, 8'hF0, 1'b1);
    simpleSearch("ternaryHit1", 8'h3C);
    simpleSearch("ternaryMiss", 8'h4C);

    doWrite(3'd2, 8'h11, 8'hFF, 1'b1);
    doWrite(3'd5, 8'h11, 8'hFF, 1'b1);
    simpleSearch("priority2", 8'h11);
    doWrite(3'd2, 8'h11, 8'hFF, 1'b0);
    applyStimulus("holdWrite5", 8'h11, 4, 1'b0, '0, '0, '0, 1'b0, 1'b1, 8'h77);

    applyStimulus("sameCycleWrite6", 8'hC3, 0, 1'b1, 3'd6, 8'hC3, 8'hFF, 1'b1, 1'b0, '0);

    // Abort a scan at idx 4 (the only 0x11 match is entry 5, reached later).
    @(negedge clk);
    search_valid = 1'b1; search_key = 8'h11;
    @(posedge clk); #1;
    search_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      checkOutput("abort/pre_valid", 32'(result_valid), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    modelClear();
    checkOutput("abort/result_valid", 32'(result_valid), 32'd0);
    checkOutput("abort/search_ready", 32'(search_ready), 32'd1);
    checkOutput("abort/wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("abort/result_hit", 32'(result_hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("abort/post_valid", 32'(result_valid), 32'd0);
    end
    simpleSearch("afterAbortMiss", 8'h11);

    for (int it = 0; it < 40; it++) begin
      logic [IDXW-1:0]  ra;
      logic [WIDTH-1:0] rk;
      int               pick;
      for (int w = 0; w < 2; w++) begin
        doWrite(IDXW'($urandom_range(DEPTH - 1)), WIDTH'($urandom), WIDTH'($urandom | $urandom),
                ($urandom_range(3) != 0));
      end
      pick = $urandom_range(DEPTH - 1);
      rk = WIDTH'($urandom);
      if ($urandom_range(1) == 1) rk = mData[pick] ^ (WIDTH'($urandom) & ~mCare[pick]);
      ra = IDXW'($urandom_range(DEPTH - 1));
      applyStimulus($sformatf("rand%0d", it), rk, $urandom_range(2),
                    ($urandom_range(3) == 0), ra, WIDTH'($urandom), WIDTH'($urandom),
                    ($urandom_range(1) == 1), ($urandom_range(3) == 0), WIDTH'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
